// File: rtl/ms2xs_coef_pack.sv
// rtl/ms2xs_coef_pack.sv - packs W-bit coefficient beats LSB-first into dense D_WIDTH-bit words
//
// Optional feature macro: MS2XS_PACK_HDR_EN (emits one header word per frame).
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous, active-low; clears all state
//   s_tdata    [W-1:0] coefficient, [W+1:W] selection tag, upper bits ignored
//   s_tvalid   input beat valid
//   s_tlast    last coefficient of the frame
//   s_tready   input ready
//   m_tdata    packed output word
//   m_tvalid   output word valid
//   m_tlast    final word of the frame
//   m_tready   downstream ready
//   pack_done  one-cycle pulse after the final word handshakes
//   len_err    sticky; the last frame did not hold exactly N coefficients
module ms2xs_coef_pack #(
  parameter int D_WIDTH = 32,
  parameter int N       = 11,
  parameter int q       = 2048
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [D_WIDTH-1:0] s_tdata,
  input  logic               s_tvalid,
  input  logic               s_tlast,
  output logic               s_tready,
  output logic [D_WIDTH-1:0] m_tdata,
  output logic               m_tvalid,
  output logic               m_tlast,
  input  logic               m_tready,
  output logic               pack_done,
  output logic               len_err
);

  localparam int W  = $clog2(q - 1);
  localparam int AW = D_WIDTH + W;
  localparam int LW = $clog2(AW);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [LW-1:0] D_LVL = LW'(D_WIDTH);
  localparam logic [LW-1:0] W_LVL = LW'(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
`ifdef MS2XS_PACK_HDR_EN
    , HDR = 2'd3
`endif
  } state_t;

  state_t          state;
  logic [AW-1:0]   acc;    // bits at and above level are always zero
  logic [LW-1:0]   level;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   ins;

  // Only the tag and coefficient fields are meaningful; the rest of the bus is ignored.
  logic unused_bits;
  assign unused_bits = ^s_tdata;

  // Coefficient placed at the current fill position; level < D_WIDTH on accept so it fits.
  assign ins = {{D_WIDTH{1'b0}}, s_tdata[W-1:0]} << level;

`ifdef MS2XS_PACK_HDR_EN
  // The tag is only consumed by the header word.
  logic [1:0]         sel;
  logic [D_WIDTH-1:0] hdr_word;

  always_comb begin
    hdr_word        = '0;
    hdr_word[1:0]   = sel;
    hdr_word[31:16] = 16'(N);
  end
`endif

  // Handshake signals are decoded from state/level only, so there is no path
  // from s_* to m_* or from m_tready to s_tready. In RUN, s_tready and m_tvalid
  // are mutually exclusive, so accept and drain never happen in the same cycle.
  always_comb begin
    s_tready = 1'b0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = acc[D_WIDTH-1:0];
    case (state)
      RUN: begin
        s_tready = (level < D_LVL);
        m_tvalid = (level >= D_LVL);
      end
      FLUSH: begin
        m_tvalid = 1'b1;
        m_tlast  = (level <= D_LVL);
      end
`ifdef MS2XS_PACK_HDR_EN
      HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = hdr_word;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      level     <= '0;
      cnt       <= '0;
      pack_done <= 1'b0;
      len_err   <= 1'b0;
`ifdef MS2XS_PACK_HDR_EN
      sel       <= '0;
`endif
    end else begin
      pack_done <= 1'b0;
      case (state)
        IDLE: begin
          // Peek at the first beat for its tag without consuming it.
          if (s_tvalid) begin
`ifdef MS2XS_PACK_HDR_EN
            sel   <= s_tdata[W+1:W];
            state <= HDR;
`else
            state <= RUN;
`endif
          end
        end
`ifdef MS2XS_PACK_HDR_EN
        HDR: begin
          if (m_tready) state <= RUN;
        end
`endif
        RUN: begin
          if (s_tvalid && s_tready) begin
            acc   <= acc | ins;
            level <= level + W_LVL;
            if (cnt != '1) cnt <= cnt + CW'(1);
            if (s_tlast) begin
              len_err <= (cnt != CNT_LAST);
              state   <= FLUSH;
            end
          end else if (m_tvalid && m_tready) begin
            acc   <= acc >> D_WIDTH;
            level <= level - D_LVL;
          end
        end
        FLUSH: begin
          if (m_tready) begin
            if (m_tlast) begin
              acc       <= '0;
              level     <= '0;
              cnt       <= '0;
              pack_done <= 1'b1;
              state     <= IDLE;
            end else begin
              acc   <= acc >> D_WIDTH;
              level <= level - D_LVL;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ms2xs_coef_pack.sv
// tb/tb_ms2xs_coef_pack.sv - self-checking bench for ms2xs_coef_pack
`timescale 1ns/1ps
module tb_ms2xs_coef_pack;

  localparam int D_WIDTH = 32;
  localparam int N       = 11;
  localparam int Q       = 2048;
  localparam int W       = 11;
`ifdef MS2XS_PACK_HDR_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [D_WIDTH-1:0] s_tdata;
  logic               s_tvalid;
  logic               s_tlast;
  logic               s_tready;
  logic [D_WIDTH-1:0] m_tdata;
  logic               m_tvalid;
  logic               m_tlast;
  logic               m_tready;
  logic               pack_done;
  logic               len_err;

  always #5 clk = ~clk;

  ms2xs_coef_pack #(.D_WIDTH(D_WIDTH), .N(N), .q(Q)) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .pack_done(pack_done), .len_err(len_err)
  );

  typedef struct {
    int len;
    int tag;
    bit rnd;
    int bp;
    int words;
    bit err;
  } vec_t;

  vec_t vecs[10];

  int checks = 0;
  int failures = 0;

  int                 tx_coef[$];
  int                 tx_tag;
  logic [D_WIDTH-1:0] rx_word[$];
  bit                 rx_last[$];
  logic [D_WIDTH-1:0] exp_word[$];
  logic [D_WIDTH-1:0] nom_words[$];
  int                 done_cnt;
  int                 first_accept;
  bit                 stall_seen;
  bit                 timed_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: lay the coefficients out as one long bit string, LSB first,
  // and cut it into D_WIDTH-bit words, zero padding the last one.
  task automatic build_model();
    bit                 bits[$];
    int                 nw;
    logic [D_WIDTH-1:0] word;
    exp_word.delete();
    if (HDR_WORDS > 0) begin
      word = '0;
      word[31:16] = 16'(N);
      word[1:0]   = 2'(tx_tag);
      exp_word.push_back(word);
    end
    foreach (tx_coef[i])
      for (int b = 0; b < W; b++) bits.push_back(((tx_coef[i] >> b) & 1) != 0);
    nw = (bits.size() + D_WIDTH - 1) / D_WIDTH;
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int b = 0; b < D_WIDTH; b++)
        if (w * D_WIDTH + b < bits.size()) word[b] = bits[w * D_WIDTH + b];
      exp_word.push_back(word);
    end
  endtask

  // bp: 0 always ready, 1 random ready and random input gaps, 2 ten-cycle stall.
  // stop_after >= 0 abandons the frame once that many beats were accepted.
  task automatic run_frame(input int bp, input int stop_after);
    int                 beat, cyc, tail;
    bit                 got_last, hold_valid, hold_last;
    logic [D_WIDTH-1:0] hold_data, junk;
    beat = 0; cyc = 0; tail = 0;
    got_last = 0; hold_valid = 0; hold_last = 0; hold_data = '0;
    rx_word.delete(); rx_last.delete();
    done_cnt = 0; first_accept = -1; stall_seen = 0; timed_out = 0;
    while (tail < 3) begin
      if (cyc >= 1000) begin
        timed_out = 1;
        break;
      end
      @(negedge clk);
      if (stop_after >= 0 && beat == stop_after) break;
      if (!got_last && beat < tx_coef.size() && (bp != 1 || $urandom_range(3) != 0)) begin
        junk     = D_WIDTH'($urandom);
        junk     = junk << (W + 2);
        s_tvalid = 1'b1;
        s_tdata  = junk | (D_WIDTH'(tx_tag & 3) << W) | D_WIDTH'(tx_coef[beat]);
        s_tlast  = (beat == tx_coef.size() - 1);
      end else begin
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
      end
      case (bp)
        1:       m_tready = ($urandom_range(1) == 1);
        2:       m_tready = !(cyc >= 4 && cyc < 14);
        default: m_tready = 1'b1;
      endcase
      #1;
      if (pack_done) done_cnt++;
      checks++;
      if (s_tready && m_tvalid) begin
        failures++;
        $display("FAIL ready_valid_exclusive: actual s_tready=1 m_tvalid=1 required not both");
      end
      if (hold_valid) begin
        checks++;
        if (!m_tvalid || m_tdata !== hold_data || m_tlast !== hold_last) begin
          failures++;
          $display("FAIL hold_stable: actual v=%0b d=0x%0h l=%0b required v=1 d=0x%0h l=%0b",
                   m_tvalid, m_tdata, m_tlast, hold_data, hold_last);
        end
      end
      hold_valid = m_tvalid && !m_tready;
      hold_data  = m_tdata;
      hold_last  = m_tlast;
      if (bp == 2 && m_tvalid && !m_tready && !s_tready) stall_seen = 1;
      if (s_tvalid && s_tready) begin
        if (first_accept < 0) first_accept = cyc;
        beat++;
      end
      if (got_last) begin
        check("no_word_after_last", m_tvalid, 0);
        tail++;
      end else if (m_tvalid && m_tready) begin
        rx_word.push_back(m_tdata);
        rx_last.push_back(m_tlast);
        if (m_tlast) got_last = 1;
      end
      cyc++;
    end
    if (stop_after < 0) check("frame_timeout", timed_out, 0);
  endtask

  task automatic compare_frame(input string tag, input int exp_words, input bit exp_err);
    int n;
    check({tag, "_words"}, rx_word.size(), exp_words);
    n = (rx_word.size() < exp_word.size()) ? rx_word.size() : exp_word.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), rx_word[i], exp_word[i]);
      check($sformatf("%s_last%0d", tag, i), rx_last[i], (i == exp_word.size() - 1));
    end
    check({tag, "_pack_done"}, done_cnt, 1);
    check({tag, "_len_err"}, len_err, exp_err);
  endtask

  initial begin
    vecs[0] = '{len: 11, tag: 2, rnd: 0, bp: 0, words: 4,  err: 0};
    vecs[1] = '{len: 11, tag: 0, rnd: 0, bp: 2, words: 4,  err: 0};
    vecs[2] = '{len: 6,  tag: 0, rnd: 0, bp: 0, words: 3,  err: 1};
    vecs[3] = '{len: 11, tag: 0, rnd: 0, bp: 0, words: 4,  err: 0};
    vecs[4] = '{len: 11, tag: 3, rnd: 0, bp: 0, words: 4,  err: 0};
    vecs[5] = '{len: 14, tag: 1, rnd: 1, bp: 1, words: 5,  err: 1};
    vecs[6] = '{len: 27, tag: 0, rnd: 1, bp: 0, words: 10, err: 1};
    vecs[7] = '{len: 32, tag: 0, rnd: 0, bp: 1, words: 11, err: 1};
    vecs[8] = '{len: 1,  tag: 0, rnd: 1, bp: 0, words: 1,  err: 1};
    vecs[9] = '{len: 11, tag: 1, rnd: 1, bp: 1, words: 4,  err: 0};

    reset = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_pack_done", pack_done, 0);
    check("rst_len_err", len_err, 0);
    reset = 1'b1;

    for (int v = 0; v < 10; v++) begin
      tx_coef.delete();
      tx_tag = vecs[v].tag;
      for (int i = 0; i < vecs[v].len; i++)
        tx_coef.push_back(vecs[v].rnd ? int'($urandom_range(Q - 1)) : i);
      build_model();
      run_frame(vecs[v].bp, -1);
      compare_frame($sformatf("vec%0d", v), vecs[v].words + HDR_WORDS, vecs[v].err);
      if (v == 0) begin
        check("nominal_first_accept", first_accept, 1 + HDR_WORDS);
        if (rx_word.size() == 4 + HDR_WORDS) begin
          check("nominal_word0", rx_word[HDR_WORDS], 32'h0080_0800);
          check("nominal_word3_pad", rx_word[3 + HDR_WORDS][31:25], 0);
`ifdef MS2XS_PACK_HDR_EN
          check("header_word", rx_word[0], 32'h000B_0002);
`endif
        end
        nom_words.delete();
        for (int i = HDR_WORDS; i < rx_word.size(); i++) nom_words.push_back(rx_word[i]);
      end
      if (v == 1) check("bp_stall_seen", stall_seen, 1);
      if (v == 4 && rx_word.size() == nom_words.size() + HDR_WORDS)
        for (int i = 0; i < nom_words.size(); i++)
          check($sformatf("tag_ignored%0d", i), rx_word[i + HDR_WORDS], nom_words[i]);
    end

    for (int r = 0; r < 8; r++) begin
      int len;
      len = int'($urandom_range(40, 1));
      tx_coef.delete();
      tx_tag = int'($urandom_range(3));
      for (int i = 0; i < len; i++) tx_coef.push_back(int'($urandom_range(Q - 1)));
      build_model();
      run_frame(int'($urandom_range(1)), -1);
      compare_frame($sformatf("rand%0d", r), exp_word.size(), (len != N));
    end

    // Reset in the middle of a frame, then a clean nominal frame.
    tx_coef.delete();
    tx_tag = 0;
    for (int i = 0; i < 11; i++) tx_coef.push_back(i);
    run_frame(0, 5);
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_s_tready", s_tready, 0);
    check("midrst_m_tvalid", m_tvalid, 0);
    check("midrst_m_tdata", m_tdata, 0);
    check("midrst_m_tlast", m_tlast, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("midrst_len_err", len_err, 0);
    build_model();
    run_frame(0, -1);
    compare_frame("after_rst", 4 + HDR_WORDS, 0);
    if (rx_word.size() == nom_words.size() + HDR_WORDS)
      for (int i = 0; i < nom_words.size(); i++)
        check($sformatf("after_rst_nom%0d", i), rx_word[i + HDR_WORDS], nom_words[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
